pwl_activation_unit: RTL

//  Parametrised piecewise-linear activation for a neural-network layer. A signed input is split

---
 rtl/pwl_activation_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/pwl_activation_unit.sv
// Piecewise-linear activation: a LUT lookup feeds a 3-stage interpolate/saturate pipeline.
// The LUT can be rewritten at runtime and reloads a default ramp on reset.
module pwl_activation_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);
    localparam int FRAC_W = DATA_W - ADDR_W;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int HALF   = 2 ** (ADDR_W - 1);
    localparam int PROD_W = DATA_W + FRAC_W + 2;
    localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(HALF - 1);
    localparam logic signed [PROD_W-1:0] SMAX = PROD_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SMIN = -PROD_W'(2 ** (DATA_W - 1));

    logic signed [DATA_W-1:0] lut [DEPTH];

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] nxt_addr;
    logic [FRAC_W-1:0] frac;
    logic              en;

    // Handshake: a sample moves on in_valid & in_ready and leaves on out_valid & out_ready;
    // the whole pipeline advances as one whenever the output slot is empty or being drained.
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;

    assign addr = x[DATA_W-1 -: ADDR_W];
    assign frac = x[FRAC_W-1:0];

    // The index is two's-complement ordered, so plain increment wraps -1 to 0 for free.
    always_comb begin
        nxt_addr = addr + ADDR_W'(1);
        if (addr == TOP_ADDR) nxt_addr = addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                lut[i] <= (i < HALF) ? DATA_W'(i << FRAC_W) : '0;
        end else if (wr_en) begin
            lut[wr_addr] <= wr_data;
        end
    end

    logic                     v1, v2, v3;
    logic signed [DATA_W-1:0] b1, n1, b2;
    logic [FRAC_W-1:0]        f1;
    logic                     m1;
    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] prod, p2, sum;
    logic [DATA_W-1:0]        ysat;

    always_comb begin
        diff = {n1[DATA_W-1], n1} - {b1[DATA_W-1], b1};
        prod = PROD_W'(diff) * PROD_W'($signed({1'b0, f1}));
        sum  = PROD_W'(b2) + (p2 >>> FRAC_W);
        ysat = sum[DATA_W-1:0];
        if (sum > SMAX) ysat = SMAX[DATA_W-1:0];
        else if (sum < SMIN) ysat = SMIN[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            b1 <= '0;
            n1 <= '0;
            f1 <= '0;
            m1 <= 1'b0;
            b2 <= '0;
            p2 <= '0;
            y  <= '0;
        end else if (en) begin
            v1 <= in_valid;
            b1 <= lut[addr];
            n1 <= lut[nxt_addr];
            f1 <= frac;
            m1 <= mode;
            v2 <= v1;
            b2 <= b1;
            p2 <= m1 ? '0 : prod;
            v3 <= v2;
            y  <= ysat;
        end
    end

    assign out_valid = v3;
endmodule
